// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word fetches over a req/ack memory port into a small
// prefetch FIFO and hands {instr, pc} pairs to decode; redirects flush it.
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i
);

    localparam int             PTR_W   = $clog2(FIFO_DEPTH);
    localparam int             CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t                r_state;
    logic                  r_req;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_fetch_pc;

    logic [DATA_WIDTH-1:0] r_instr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_pc_mem    [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_nonempty;
    logic                  w_ack;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count_next;
    logic [DATA_WIDTH-1:0] w_target;
    logic [DATA_WIDTH-1:0] w_pc_inc;
    logic                  w_unused_lsbs;

    assign w_nonempty    = (r_count != '0);
    assign w_ack         = r_req & mem_ack_i;
    // A redirect overrides both sides of the FIFO in the same cycle.
    assign w_push        = (r_state == REQ) & w_ack & ~redirect_i;
    assign w_pop         = w_nonempty & instr_ready_i & ~redirect_i;
    assign w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_target      = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
    assign w_pc_inc      = r_fetch_pc + DATA_WIDTH'(4);
    assign w_unused_lsbs = ^redirect_pc_i[1:0];

    assign mem_req_o     = r_req;
    assign mem_addr_o    = r_addr;
    assign instr_valid_o = w_nonempty;
    assign instr_o       = w_nonempty ? r_instr_mem[r_rptr] : '0;
    assign instr_pc_o    = w_nonempty ? r_pc_mem[r_rptr]    : '0;

    // Request FSM; mem_addr_o always equals fetch_pc while in REQ.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            case (r_state)
                IDLE: begin
                    if (redirect_i) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_addr  <= w_target;
                    end else if (r_count < DEPTH_C) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                    end
                end
                REQ: begin
                    if (redirect_i) begin
                        if (w_ack) begin
                            r_addr <= w_target;
                        end else begin
                            r_state <= DISCARD;
                        end
                    end else if (w_ack) begin
                        if (w_count_next < DEPTH_C) begin
                            r_addr <= w_pc_inc;
                        end else begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (w_ack) begin
                        r_state <= REQ;
                        r_addr  <= redirect_i ? w_target : r_fetch_pc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase

            if (redirect_i) begin
                r_fetch_pc <= w_target;
            end else if (w_push) begin
                r_fetch_pc <= w_pc_inc;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Storage needs no reset: the outputs are gated by the count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_instr_mem[r_wptr] <= mem_rdata_i;
            r_pc_mem[r_wptr]    <= r_addr;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a responding memory, a transaction-level
// fetch model and a scoreboard of {instr, pc} pairs expected at decode.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      expQ[$];
    logic [31:0] modelPc;
    bit          modelDiscard;
    int          assertCount;
    int          failCount;

    instr_fetch_unit #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_ready_i(instr_ready_i)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        expQ.delete();
        modelPc      = 32'h0;
        modelDiscard = 1'b0;
    endtask

    // Called #1 after a rising edge: checks the FIFO head, updates the model
    // for the coming edge, drives the inputs and advances one cycle.
    task automatic applyStimulus(input bit ack, input bit ready, input bit redir, input logic [31:0] rpc);
        entry_t e;
        checkOutput("validVsModel", {31'b0, instr_valid_o}, {31'b0, expQ.size() != 0});
        if (expQ.size() == 0) begin
            checkOutput("emptyInstr", instr_o, 32'h0);
            checkOutput("emptyPc", instr_pc_o, 32'h0);
        end else if (ready && !redir) begin
            e = expQ.pop_front();
            checkOutput("headPc", instr_pc_o, e.pc);
            checkOutput("headInstr", instr_o, e.instr);
        end

        if (redir) begin
            expQ.delete();
            modelPc = {rpc[31:2], 2'b00};
            if (mem_req_o) modelDiscard = !ack;
        end else if (ack && mem_req_o) begin
            if (modelDiscard) begin
                modelDiscard = 1'b0;
            end else begin
                checkOutput("fetchAddr", mem_addr_o, modelPc);
                e.instr = memFn(modelPc);
                e.pc    = modelPc;
                expQ.push_back(e);
                modelPc = modelPc + 32'd4;
            end
        end

        mem_ack_i     = ack;
        mem_rdata_i   = memFn(mem_addr_o);
        instr_ready_i = ready;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RST           = 1'b1;
        mem_ack_i     = 1'b0;
        redirect_i    = 1'b0;
        instr_ready_i = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        modelReset();
    endtask

    initial begin
        assertCount   = 0;
        failCount     = 0;
        RST           = 1'b1;
        mem_ack_i     = 1'b0;
        mem_rdata_i   = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;
        modelReset();
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rstReq", {31'b0, mem_req_o}, 32'h0);
        checkOutput("rstAddr", mem_addr_o, 32'h0);
        checkOutput("rstValid", {31'b0, instr_valid_o}, 32'h0);
        checkOutput("rstInstr", instr_o, 32'h0);
        checkOutput("rstPc", instr_pc_o, 32'h0);
        RST = 1'b0;

        $display("[TB] zero-wait streaming");
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 32'h0);

        $display("[TB] fill with decode stalled");
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 32'h0);
        checkOutput("fullReqLow", {31'b0, mem_req_o}, 32'h0);
        checkOutput("fullHeadPc", instr_pc_o, 32'h0);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("onePopReqLow", {31'b0, mem_req_o}, 32'h0);
        applyStimulus(1, 0, 0, 32'h0);
        checkOutput("refillReq", {31'b0, mem_req_o}, 32'h1);
        checkOutput("refillAddr", mem_addr_o, 32'h10);
        applyStimulus(1, 0, 0, 32'h0);
        checkOutput("refullReqLow", {31'b0, mem_req_o}, 32'h0);

        $display("[TB] redirect during a waiting request");
        doReset();
        applyStimulus(1, 1, 0, 32'h0);
        applyStimulus(1, 1, 0, 32'h0);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("waitAddr0", mem_addr_o, 32'h8);
        applyStimulus(0, 1, 1, 32'h100);
        for (int i = 1; i <= 3; i++) begin
            checkOutput($sformatf("holdAddr%0d", i), mem_addr_o, 32'h8);
            checkOutput($sformatf("holdReq%0d", i), {31'b0, mem_req_o}, 32'h1);
            applyStimulus((i == 3), 1, 0, 32'h0);
        end
        checkOutput("targetAddr", mem_addr_o, 32'h100);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("targetPc", instr_pc_o, 32'h100);
        applyStimulus(1, 1, 0, 32'h0);

        $display("[TB] redirect with ack and pop in the same cycle");
        checkOutput("preRedirValid", {31'b0, instr_valid_o}, 32'h1);
        applyStimulus(1, 1, 1, 32'h203);
        checkOutput("flushValid", {31'b0, instr_valid_o}, 32'h0);
        checkOutput("alignedAddr", mem_addr_o, 32'h200);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("alignedPc", instr_pc_o, 32'h200);

        $display("[TB] address wrap");
        applyStimulus(1, 1, 1, 32'hFFFF_FFFC);
        checkOutput("wrapAddr0", mem_addr_o, 32'hFFFF_FFFC);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("wrapAddr1", mem_addr_o, 32'h0);
        checkOutput("wrapPc", instr_pc_o, 32'hFFFF_FFFC);
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("wrapAddr2", mem_addr_o, 32'h4);
        applyStimulus(1, 1, 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h0);

        $display("[TB] reset mid-transaction");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 32'h0);
        checkOutput("preRstAddr", mem_addr_o, 32'hC);
        checkOutput("preRstPc", instr_pc_o, 32'h0);
        RST         = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        checkOutput("asyncReq", {31'b0, mem_req_o}, 32'h0);
        checkOutput("asyncAddr", mem_addr_o, 32'h0);
        checkOutput("asyncValid", {31'b0, instr_valid_o}, 32'h0);
        checkOutput("asyncInstr", instr_o, 32'h0);
        checkOutput("asyncPc", instr_pc_o, 32'h0);
        @(posedge CLK);
        #1;
        checkOutput("staleAckValid", {31'b0, instr_valid_o}, 32'h0);
        RST       = 1'b0;
        mem_ack_i = 1'b0;
        modelReset();
        applyStimulus(1, 1, 0, 32'h0);
        checkOutput("postRstReq", {31'b0, mem_req_o}, 32'h1);
        checkOutput("postRstAddr", mem_addr_o, 32'h0);
        applyStimulus(1, 1, 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
